// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready word intake into a FIFO, serialised on txd.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_data, tx_valid   word to send and its valid strobe
//   tx_ready            FIFO can accept a word this cycle
//   txd                 serial line, idle high
//   busy                FIFO non-empty or frame in progress
//   fifo_count          words held in the FIFO, excluding the frame being shifted
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Elaboration-time parameter legality
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: bit time must be at least 2 clocks");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_d;
  logic                 bit_end;
  logic                 fifo_nonempty;

  // FIFO bookkeeping; a full FIFO refuses pushes regardless of a same-cycle pop
  assign push          = tx_valid && tx_ready;
  assign head          = mem[rd_ptr];
  assign head_par      = (PARITY == 1) ? ~^head : ^head;
  assign fifo_nonempty = (fifo_count != '0);
  assign count_d       = fifo_count + CW'(push) - CW'(pop);
  assign bit_end       = (cnt_q == CNT_W'(DIV - 1));

  // Next-state, baud counter and next line level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd;
    pop     = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a word is waiting
            if (fifo_nonempty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = head_par;
              cnt_d   = '0;
              bit_d   = '0;
              state_d = S_START;
              txd_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_d;
      txd        <= txd_d;
      tx_ready   <= (count_d != CW'(FIFO_DEPTH));
      busy       <= (state_d != S_IDLE) || (count_d != '0);
    end
  end

  // Storage needs no reset; only pointer-qualified entries are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule
